// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 size codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: little-endian load extraction with sign/zero extension,
// and sub-word store merge into an existing memory word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Halfwords look at offset[1] only, words ignore the offset: misalignment truncates.
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = rdata;
        endcase

        merged = rdata;
        case (funct3[1:0])
            2'b00: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-wide memory, sub-word
// stores as read-modify-write. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_t state, state_nxt;

    logic                     lat_we;
    logic [2:0]               lat_f3;
    logic [ADDRESS_WIDTH+1:0] lat_addr;
    logic [31:0]              lat_wdata;
    logic [31:0]              merged_q;
    logic [31:0]              load_data;
    logic [31:0]              merged;
    logic                     accept;
    logic                     illegal;
    logic                     unused_addr;

    // Address bits above the memory window alias and are deliberately dropped.
    assign unused_addr = ^req_addr[31:ADDRESS_WIDTH+2];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        if (req_we) illegal = req_funct3[2] || (req_funct3 == 3'b011);
        else        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])          illegal = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) illegal = 1'b1;
`endif
    end

    lsu_lane u_lane (
        .funct3    (lat_f3),
        .offset    (lat_addr[1:0]),
        .rdata     (mem_rdata),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // mem_we is qualified by rst_n so a reset edge can never commit a write.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (accept && !illegal) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_addr = lat_addr[ADDRESS_WIDTH+1:2];
                if (lat_we && lat_f3[1:0] == 2'b10) begin
                    mem_we    = rst_n;
                    mem_wdata = lat_wdata;
                    state_nxt = IDLE;
                end else if (lat_we) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                mem_addr  = lat_addr[ADDRESS_WIDTH+1:2];
                mem_we    = rst_n;
                mem_wdata = merged_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            lat_we    <= 1'b0;
            lat_f3    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            merged_q  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr[ADDRESS_WIDTH+1:0];
                lat_wdata <= req_wdata;
                if (illegal) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (state == ACCESS) begin
                if (!lat_we) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                end else if (lat_f3[1:0] == 2'b10) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end else begin
                    merged_q <= merged;
                end
            end
            if (state == WRITE) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, behavioural byte-level reference,
// per-cycle response compare and directed literal cases (honours LSU_MISALIGN_CHECK_EN).
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, posedge write; preloaded from init_vals.
    logic [31:0] mem      [0:65535];
    logic [31:0] init_vals[0:63];
    logic [31:0] ref_mem  [0:63];
    logic        load_init = 1'b0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_vals[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          wcount = 0;
    logic [31:0] hold_rdata = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    // Response compare: every cycle out of reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            wcount = 0;
        end else begin
            if (mem_we) wcount++;
            check("we_in_idle", {31'b0, mem_we & req_ready}, 32'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    cur = q.pop_front();
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
                    check("rsp_rdata", rsp_rdata, cur.rdata);
                    check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    check("write_pulses", 32'(wcount), 32'(cur.writes));
                    hold_rdata = cur.rdata;
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
                wcount = 0;
            end else begin
                check("rdata_hold", rsp_rdata, hold_rdata);
            end
        end
    end

    // Reference: what a request must return and how it changes memory, at byte level.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output exp_t e);
        int          w;
        int          bofs;
        int          hofs;
        int          v;
        logic        ill;
        logic [31:0] word;
        logic [31:0] mask;
        w    = int'(addr[17:2]);
        bofs = int'(addr[1:0]);
        hofs = addr[1] ? 2 : 0;
        word = ref_mem[w];
        e.rdata = 32'd0; e.err = 1'b0; e.writes = 0; e.lat = 2; e.acc = 0;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (f3[1:0] == 2'b01 && addr[0]) ill = 1'b1;
        if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) ill = 1'b1;
`endif
        if (ill) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            case (f3)
                3'd0, 3'd4: begin
                    v = int'((word >> (8 * bofs)) & 32'hFF);
                    if (f3 == 3'd0 && v >= 128) v -= 256;
                    e.rdata = 32'(v);
                end
                3'd1, 3'd5: begin
                    v = int'((word >> (8 * hofs)) & 32'hFFFF);
                    if (f3 == 3'd1 && v >= 32768) v -= 65536;
                    e.rdata = 32'(v);
                end
                default: e.rdata = word;
            endcase
        end else begin
            e.writes = 1;
            if (f3 == 3'd2) begin
                ref_mem[w] = wd;
            end else if (f3 == 3'd0) begin
                mask = 32'hFF << (8 * bofs);
                ref_mem[w] = (word & ~mask) | ((wd & 32'hFF) << (8 * bofs));
                e.lat = 3;
            end else begin
                mask = 32'hFFFF << (8 * hofs);
                ref_mem[w] = (word & ~mask) | ((wd & 32'hFFFF) << (8 * hofs));
                e.lat = 3;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic rsp_at_accept);
        exp_t e;
        int   n = 0;
        rsp_at_accept = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        rsp_at_accept = rsp_valid;
        model(we, f3, addr, wd, e);
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("rsp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    logic        b2b;
    logic [31:0] r;
    int          diffs;

    initial begin
        for (int i = 0; i < 64; i++) begin
            init_vals[i] = $urandom;
            ref_mem[i]   = init_vals[i];
        end
        init_vals[4] = 32'h8899_AABB;
        ref_mem[4]   = 32'h8899_AABB;
        init_vals[8] = 32'h0;
        ref_mem[8]   = 32'h0;

        load_init = 1'b1;
        @(negedge clk);
        load_init = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 3'b000, 32'h11, 32'h0, b2b); drain();
        check("lit_lb", last_rdata, 32'hFFFF_FFAA);
        send(1'b0, 3'b100, 32'h11, 32'h0, b2b); drain();
        check("lit_lbu", last_rdata, 32'h0000_00AA);
        send(1'b0, 3'b001, 32'h12, 32'h0, b2b); drain();
        check("lit_lh", last_rdata, 32'hFFFF_8899);
        send(1'b0, 3'b101, 32'h12, 32'h0, b2b); drain();
        check("lit_lhu", last_rdata, 32'h0000_8899);
        send(1'b0, 3'b010, 32'h10, 32'h0, b2b); drain();
        check("lit_lw", last_rdata, 32'h8899_AABB);
        send(1'b1, 3'b000, 32'h13, 32'h1234_5677, b2b); drain();
        check("lit_sb_mem", mem[4], 32'h7799_AABB);
        check("lit_sb_rdata", last_rdata, 32'h0);
        send(1'b0, 3'b010, 32'h0004_0010, 32'h0, b2b); drain();
        check("lit_alias", last_rdata, 32'h7799_AABB);

        send(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, b2b);
        send(1'b0, 3'b010, 32'h20, 32'h0, b2b);
        check("lit_b2b_accept", {31'b0, b2b}, 32'd1);
        drain();
        check("lit_sw_lw", last_rdata, 32'hDEAD_BEEF);

        send(1'b0, 3'b111, 32'h10, 32'h0, b2b); drain();
        check("lit_bad_f3_err", {31'b0, last_err}, 32'd1);

        send(1'b0, 3'b010, 32'h22, 32'h0, b2b); drain();
`ifdef LSU_MISALIGN_CHECK_EN
        check("lit_misalign_err", {31'b0, last_err}, 32'd1);
`else
        check("lit_misalign_trunc", last_rdata, 32'hDEAD_BEEF);
`endif

        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            send(r[8], r[11:9], {r[31:18], 10'b0, r[7:0]}, $urandom, b2b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset while an SH sits in WRITE: the write must be dropped.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h24; req_wdata = 32'h0000_5A5A;
        check("rw_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw_no_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        check("rw_mem_kept", mem[9], ref_mem[9]);
        check("rw_no_rsp", {31'b0, rsp_valid}, 32'd0);
        check("rw_ready_after", {31'b0, req_ready}, 32'd1);
        hold_rdata = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rw_no_late_rsp", 32'(q.size()), 32'd0);

        diffs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_final", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the CPU execute stage and the word-wide data memory.
- The data memory has a combinational read and a posedge write. Its ports are a word address, a write enable, 32-bit write data and 32-bit read data.
- Converts RISC-V byte, halfword and word loads/stores into whole-word memory accesses, with little-endian lane selection and sign or zero extension.
- Sub-word stores are done as a registered read-modify-write sequence.

Parameters:
- ADDRESS_WIDTH, 16, memory word-address width; CPU byte address bits [ADDRESS_WIDTH+1:2] drive mem_addr.
- DATA_WIDTH, 32, memory word width; only 32 is supported.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  LSU can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  32  extended load data, valid with rsp_valid
- rsp_err  out  1  request rejected, valid with rsp_valid
- mem_addr  out  ADDRESS_WIDTH  word address to data memory
- mem_we  out  1  data memory write enable
- mem_wdata  out  DATA_WIDTH  data memory write data
- mem_rdata  in  DATA_WIDTH  data memory read data, combinational from mem_addr

Behaviour:
- Reset (rst_n low at posedge): state IDLE; rsp_valid, rsp_err, rsp_rdata and all latched request registers cleared to 0.
- mem_we is gated by rst_n, so no write occurs at a reset edge, including reset during WRITE or a SW access. Any in-flight request is dropped with no response.
- States: IDLE, ACCESS, WRITE.
- req_ready = (state == IDLE).
- Handshake: a transfer happens on an edge where req_valid && req_ready. On that edge the LSU latches we, funct3, addr and wdata, then moves to ACCESS.
- If the request is illegal on that edge, the LSU stays in IDLE and sets rsp_valid=1, rsp_err=1 on the next cycle. Illegal means:
  - load funct3 of 011, 110 or 111;
  - store funct3 with bit 2 set or equal to 011.
- In ACCESS and WRITE, mem_addr = latched addr[ADDRESS_WIDTH+1:2]. In IDLE it is don't-care; drive 0.
- ACCESS, load: lane-select mem_rdata using addr[1:0] (little-endian).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Result registered into rsp_rdata; rsp_valid=1 next cycle; go to IDLE.
- ACCESS, SW: mem_we=1, mem_wdata=wdata; rsp_valid=1 next cycle; go to IDLE.
- ACCESS, SB/SH: register the merged word (mem_rdata with the target lane replaced by the wdata low byte/half); go to WRITE.
- WRITE: mem_we=1, mem_wdata=merged register; rsp_valid=1 next cycle; go to IDLE.
- Latency from accept edge to rsp_valid high:
  - loads, SW: 2 cycles;
  - SB/SH: 3 cycles;
  - illegal requests: 1 cycle.
- rsp_rdata holds its value until the next load completes. It is 0 on store or error responses.
- Back-to-back: the cycle rsp_valid is high, state is IDLE, so a new request is accepted that same cycle.
- mem_we is never asserted in IDLE.
- Address wrap: upper address bits above ADDRESS_WIDTH+1 are ignored, so addresses alias.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a misaligned request is treated as illegal. Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0. Result: rsp_err=1, no memory access, 1-cycle latency.
- Undefined: alignment is enforced by truncation. Halfword uses addr[1] only; word ignores addr[1:0]. No error is raised for misalignment.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the state enum lsu_state_t {IDLE, ACCESS, WRITE}.
- One natural sub-module, lsu_lane: purely combinational load-extract and store-merge for a given funct3/offset. Unit-testable alone.

Test Plan:
- Preload word 0x0000_0004 = 0x8899_AABB; LB addr 0x11 -> rsp_rdata 0xFFFF_FFAA 2 cycles after accept; LBU -> 0x0000_00AA.
- LH addr 0x12 on the same word -> 0xFFFF_8899; LHU -> 0x0000_8899; LW addr 0x10 -> 0x8899_AABB.
- SB addr 0x13, wdata 0x1234_5677 -> single mem_we pulse in WRITE; word becomes 0x7799_AABB; rsp_valid 3 cycles after accept.
- SW addr 0x20, wdata 0xDEAD_BEEF immediately followed by LW addr 0x20 -> second request accepted the cycle rsp_valid is high; load returns 0xDEAD_BEEF.
- Load funct3 3'b111 -> rsp_err=1 the next cycle, mem_we never set.
  - With LSU_MISALIGN_CHECK_EN: LW addr 0x22 -> rsp_err=1.
  - Without the macro: LW addr 0x22 returns the word at 0x20.
- Assert rst_n=0 while in WRITE for an SH -> no mem_we at that edge, memory unchanged, rsp_valid stays 0, req_ready=1 after reset.
